// File: rtl/rt_mem_port_arbiter.sv
// rtl/rt_mem_port_arbiter.sv - round-robin arbiter sharing one OBI-style memory port
// In-order responses are routed back to the issuer through a small ID FIFO.
module rt_mem_port_arbiter #(
   parameter int NumReq    = 3,
   parameter int AddrWidth = 32,
   parameter int DataWidth = 32,
   parameter int MaxTrans  = 2
) (
   input  logic                            clk_i,
   input  logic                            rst_i,
   input  logic [NumReq-1:0]               req_i,
   input  logic [NumReq-1:0]               we_i,
   input  logic [NumReq*(DataWidth/8)-1:0] be_i,
   input  logic [NumReq*AddrWidth-1:0]     addr_i,
   input  logic [NumReq*DataWidth-1:0]     wdata_i,
   output logic [NumReq-1:0]               gnt_o,
   output logic [NumReq-1:0]               rvalid_o,
   output logic [DataWidth-1:0]            rdata_o,
   output logic [NumReq-1:0]               err_o,
   output logic                            mem_req_o,
   output logic                            mem_we_o,
   output logic [DataWidth/8-1:0]          mem_be_o,
   output logic [AddrWidth-1:0]            mem_addr_o,
   output logic [DataWidth-1:0]            mem_wdata_o,
   input  logic                            mem_gnt_i,
   input  logic                            mem_rvalid_i,
   input  logic [DataWidth-1:0]            mem_rdata_i,
   input  logic                            mem_err_i,
   output logic                            busy_o,
   output logic                            proto_err_o
);

   localparam int BeW  = DataWidth / 8;
   localparam int IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;
   localparam int PtrW = (MaxTrans > 1) ? $clog2(MaxTrans) : 1;
   localparam int CntW = $clog2(MaxTrans + 1);

   logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;
   logic            lock_q, lock_d;
   logic [IdxW-1:0] lock_idx_q, lock_idx_d;
   logic            proto_err_q, proto_err_d;
   logic [IdxW-1:0] ids_q [MaxTrans];
   logic [IdxW-1:0] ids_d [MaxTrans];
   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0] cnt_q, cnt_d;

   logic            fifo_full, fifo_empty, hs, rsp, found;
   logic [IdxW-1:0] sel, head;
   int              idx;

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == PtrW'(MaxTrans - 1)) ? '0 : p + 1'b1;
   endfunction

   assign fifo_full  = (cnt_q == CntW'(MaxTrans));
   assign fifo_empty = (cnt_q == '0);
   assign head       = ids_q[rd_ptr_q];

   // A pending (locked) address phase overrides round-robin priority.
   always_comb begin
      sel   = rr_ptr_q;
      found = 1'b0;
      idx   = 0;
      for (int i = 0; i < NumReq; i++) begin
         idx = int'(rr_ptr_q) + i;
         if (idx >= NumReq) idx = idx - NumReq;
         if (!found && req_i[IdxW'(idx)]) begin
            sel   = IdxW'(idx);
            found = 1'b1;
         end
      end
      if (lock_q) sel = lock_idx_q;
   end

   assign mem_req_o = !rst_i && req_i[sel] && !fifo_full;
   assign hs        = mem_req_o && mem_gnt_i;
   assign rsp       = !rst_i && mem_rvalid_i && !fifo_empty;

   always_comb begin
      mem_we_o    = 1'b0;
      mem_be_o    = '0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      gnt_o       = '0;
      rvalid_o    = '0;
      err_o       = '0;
      for (int k = 0; k < NumReq; k++) begin
         if (sel == IdxW'(k)) begin
            mem_we_o    = we_i[k];
            mem_be_o    = be_i[k*BeW +: BeW];
            mem_addr_o  = addr_i[k*AddrWidth +: AddrWidth];
            mem_wdata_o = wdata_i[k*DataWidth +: DataWidth];
            gnt_o[k]    = hs;
         end
         if (head == IdxW'(k)) begin
            rvalid_o[k] = rsp;
            err_o[k]    = rsp && mem_err_i;
         end
      end
   end

   assign rdata_o     = mem_rdata_i;
   assign busy_o      = !fifo_empty;
   assign proto_err_o = proto_err_q;

   always_comb begin
      rr_ptr_d    = rr_ptr_q;
      lock_d      = lock_q;
      lock_idx_d  = lock_idx_q;
      proto_err_d = proto_err_q;
      ids_d       = ids_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      cnt_d       = cnt_q;
      if (hs) begin
         ids_d[wr_ptr_q] = sel;
         wr_ptr_d        = ptr_inc(wr_ptr_q);
         rr_ptr_d        = (sel == IdxW'(NumReq - 1)) ? '0 : sel + 1'b1;
         lock_d          = 1'b0;
      end else if (mem_req_o) begin
         lock_d     = 1'b1;
         lock_idx_d = sel;
      end else if (lock_q && !req_i[lock_idx_q]) begin
         lock_d      = 1'b0;
         proto_err_d = 1'b1;
      end
      if (rsp) rd_ptr_d = ptr_inc(rd_ptr_q);
      if (mem_rvalid_i && fifo_empty) proto_err_d = 1'b1;
      if (hs && !rsp) cnt_d = cnt_q + 1'b1;
      else if (!hs && rsp) cnt_d = cnt_q - 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rr_ptr_q    <= '0;
         lock_q      <= 1'b0;
         lock_idx_q  <= '0;
         proto_err_q <= 1'b0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         cnt_q       <= '0;
      end else begin
         rr_ptr_q    <= rr_ptr_d;
         lock_q      <= lock_d;
         lock_idx_q  <= lock_idx_d;
         proto_err_q <= proto_err_d;
         ids_q       <= ids_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         cnt_q       <= cnt_d;
      end
   end

endmodule

// File: tb/tb_rt_mem_port_arbiter.sv
// tb/tb_rt_mem_port_arbiter.sv - scoreboard bench for rt_mem_port_arbiter
module tb_rt_mem_port_arbiter;

   localparam int N  = 3;
   localparam int AW = 32;
   localparam int DW = 32;

   logic              clk = 1'b0;
   logic              rst_i;
   logic [N-1:0]      req_i, we_i;
   logic [N*4-1:0]    be_i;
   logic [N*AW-1:0]   addr_i;
   logic [N*DW-1:0]   wdata_i;
   logic [N-1:0]      gnt_o, rvalid_o, err_o;
   logic [DW-1:0]     rdata_o;
   logic              mem_req_o, mem_we_o;
   logic [3:0]        mem_be_o;
   logic [AW-1:0]     mem_addr_o;
   logic [DW-1:0]     mem_wdata_o;
   logic              mem_gnt_i, mem_rvalid_i, mem_err_i;
   logic [DW-1:0]     mem_rdata_i;
   logic              busy_o, proto_err_o;

   typedef struct {
      logic [N-1:0]  v;
      logic [DW-1:0] d;
      logic          e;
   } rsp_t;

   logic [N-1:0] exp_gnt[$];
   rsp_t         exp_rsp[$];
   int           total = 0;
   int           bad = 0;

   rt_mem_port_arbiter #(.NumReq(N), .AddrWidth(AW), .DataWidth(DW), .MaxTrans(2)) dut (
      .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .we_i(we_i), .be_i(be_i),
      .addr_i(addr_i), .wdata_i(wdata_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o),
      .rdata_o(rdata_o), .err_o(err_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
      .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
      .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
      .mem_err_i(mem_err_i), .busy_o(busy_o), .proto_err_o(proto_err_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic setr(input int k, input logic r, input logic [AW-1:0] a);
      req_i[k] = r;
      addr_i[k*AW +: AW] = a;
   endtask

   task automatic resp(input logic [N-1:0] v, input logic [DW-1:0] d, input logic e);
      rsp_t r;
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = d;
      mem_err_i    = e;
      r.v = v; r.d = d; r.e = e;
      exp_rsp.push_back(r);
   endtask

   task automatic idle_rsp();
      mem_rvalid_i = 1'b0;
      mem_err_i    = 1'b0;
   endtask

   // Monitor: every grant/response the DUT presents must match the next expectation.
   always @(negedge clk) begin
      if (!rst_i) begin
         if (gnt_o != '0) begin
            if (exp_gnt.size() == 0) chk("unexpected_gnt", gnt_o, 0);
            else chk("gnt_order", gnt_o, exp_gnt.pop_front());
         end
         if (rvalid_o != '0) begin
            if (exp_rsp.size() == 0) chk("unexpected_rvalid", rvalid_o, 0);
            else begin
               rsp_t r;
               r = exp_rsp.pop_front();
               chk("rvalid", rvalid_o, r.v);
               chk("rdata", rdata_o, r.d);
               chk("err", err_o, r.v & {N{r.e}});
            end
         end
      end
   end

   initial begin
      rst_i = 1'b1; req_i = '0; we_i = '0; be_i = '0; addr_i = '0; wdata_i = '0;
      mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0; mem_err_i = 1'b0;
      step(); step();
      @(negedge clk);
      chk("rst_mem_req", mem_req_o, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_proto", proto_err_o, 0);
      step();
      rst_i = 1'b0;

      // Single read from requester 1, then rr pointer should favour requester 2.
      setr(1, 1, 32'h1000); mem_gnt_i = 1'b1; exp_gnt.push_back(3'b010);
      @(negedge clk);
      chk("t1_mem_req", mem_req_o, 1);
      chk("t1_addr", mem_addr_o, 32'h1000);
      chk("t1_busy0", busy_o, 0);
      step();
      setr(1, 0, 0); resp(3'b010, 32'hDEADBEEF, 0);
      @(negedge clk);
      chk("t1_busy1", busy_o, 1);
      step();
      idle_rsp();
      setr(0, 1, 32'h00A0); setr(2, 1, 32'h00C0); exp_gnt.push_back(3'b100);
      @(negedge clk);
      chk("t1_busy_end", busy_o, 0);
      chk("t1_rr_addr", mem_addr_o, 32'h00C0);
      step();
      setr(0, 0, 0); setr(2, 0, 0); resp(3'b100, 32'h0000_0222, 0);
      step();
      idle_rsp();
      rst_i = 1'b1; step(); rst_i = 1'b0;

      // Back-to-back round robin among three requesters.
      for (int k = 0; k < N; k++) setr(k, 1, 32'h2000 + k * 4);
      for (int i = 0; i < 6; i++) begin
         exp_gnt.push_back(3'(1 << (i % 3)));
         if (i > 0) resp(3'(1 << ((i - 1) % 3)), 32'h100 + i - 1, 0);
         @(negedge clk);
         chk("t2_addr", mem_addr_o, 32'h2000 + (i % 3) * 4);
         step();
      end
      req_i = '0; resp(3'b100, 32'h105, 0);
      step();
      idle_rsp();
      step();

      // Address phase held while downstream stalls.
      mem_gnt_i = 1'b0;
      setr(0, 1, 32'h00A0); setr(2, 1, 32'h00C0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("t3_hold_req", mem_req_o, 1);
         chk("t3_hold_addr", mem_addr_o, 32'h00A0);
         step();
      end
      mem_gnt_i = 1'b1; exp_gnt.push_back(3'b001);
      step();
      setr(0, 0, 0); exp_gnt.push_back(3'b100); resp(3'b001, 32'h300, 0);
      @(negedge clk);
      chk("t3_addr2", mem_addr_o, 32'h00C0);
      step();
      setr(2, 0, 0); resp(3'b100, 32'h301, 0);
      step();
      idle_rsp();
      step();

      // ID FIFO full blocks the third request until a pop has taken effect.
      setr(1, 1, 32'h0011);
      exp_gnt.push_back(3'b010); step();
      exp_gnt.push_back(3'b010); step();
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("t4_full_req", mem_req_o, 0);
         chk("t4_busy", busy_o, 1);
         step();
      end
      resp(3'b010, 32'h401, 0);
      @(negedge clk);
      chk("t4_pop_cycle_req", mem_req_o, 0);
      step();
      idle_rsp(); exp_gnt.push_back(3'b010);
      @(negedge clk);
      chk("t4_after_pop_req", mem_req_o, 1);
      chk("t4_busy2", busy_o, 1);
      step();
      setr(1, 0, 0); resp(3'b010, 32'h402, 0); step();
      resp(3'b010, 32'h403, 0); step();
      idle_rsp();
      @(negedge clk);
      chk("t4_drain_busy", busy_o, 0);
      step();

      // Write with error response.
      setr(2, 1, 32'h0500); we_i[2] = 1'b1; be_i[8 +: 4] = 4'b0011;
      wdata_i[2*DW +: DW] = 32'h55AA_1234; exp_gnt.push_back(3'b100);
      @(negedge clk);
      chk("t5_we", mem_we_o, 1);
      chk("t5_be", mem_be_o, 4'b0011);
      chk("t5_wdata", mem_wdata_o, 32'h55AA_1234);
      step();
      setr(2, 0, 0); we_i = '0; be_i = '0; resp(3'b100, 32'h0BAD, 1);
      step();
      idle_rsp();
      @(negedge clk);
      chk("t5_no_proto", proto_err_o, 0);
      step();

      // Protocol errors: stray rvalid, then locked requester withdrawing.
      mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hFFFF;
      step();
      mem_rvalid_i = 1'b0;
      @(negedge clk);
      chk("t6_stray_proto", proto_err_o, 1);
      step();
      @(negedge clk);
      chk("t6_sticky", proto_err_o, 1);
      step();
      rst_i = 1'b1; setr(0, 1, 32'h00E0);
      @(negedge clk);
      chk("t6_rst_forces_req", mem_req_o, 0);
      chk("t6_rst_gnt", gnt_o, 0);
      step();
      rst_i = 1'b0;
      @(negedge clk);
      chk("t6_rst_clears", proto_err_o, 0);
      chk("t6_req_after_rst", mem_req_o, 1);
      step();
      setr(0, 0, 0);
      @(negedge clk);
      chk("t6_drop_req", mem_req_o, 0);
      chk("t6_proto_not_yet", proto_err_o, 0);
      step();
      @(negedge clk);
      chk("t6_drop_proto", proto_err_o, 1);
      step(); step();
      @(negedge clk);
      chk("t6_drop_sticky", proto_err_o, 1);
      chk("gnt_queue_drained", exp_gnt.size(), 0);
      chk("rsp_queue_drained", exp_rsp.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
